// File: rtl/lnvd_pkg.sv
// Shared types and helpers for the LNVD sample delay line.
package lnvd_pkg;

    localparam int LNVD_DATA_W = 12;
    localparam int LNVD_NUM_CH = 4;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } lnvd_state_t;

    // Source of data_out for the most recent accepted sample set.
    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_BYP  = 2'd1,
        SEL_RAM  = 2'd2
    } lnvd_sel_t;

    function automatic int unsigned lnvd_clamp(input int unsigned cfg, input int unsigned max_depth);
        return (cfg > max_depth) ? max_depth : cfg;
    endfunction

endpackage

// File: rtl/lnvd_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, read-before-write on collision.
module lnvd_sdp_ram #(
    parameter int  WIDTH = 48,
    parameter int  DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/lnvd_sample_delay_line.sv
// Multi-channel delay by a programmable number of accepted samples, with fill tracking,
// config-change restart and range flag.
module lnvd_sample_delay_line
    import lnvd_pkg::*;
#(
    parameter int  DATA_W    = LNVD_DATA_W,
    parameter int  NUM_CH    = LNVD_NUM_CH,
    parameter int  MAX_DEPTH = 64,
    localparam int PTR_W     = $clog2(MAX_DEPTH),
    localparam int CFG_W     = $clog2(MAX_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CFG_W-1:0]         delay_cfg,
    input  logic                     in_valid,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    output logic                     out_valid,
    output logic [NUM_CH*DATA_W-1:0] data_out,
    output logic                     primed,
    output logic                     cfg_err
);

    localparam int               BUS_W    = NUM_CH * DATA_W;
    localparam int               SUM_W    = CFG_W + 1;
    localparam logic [CFG_W-1:0] MAX_CFG  = CFG_W'(MAX_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_DEPTH - 1);

    logic [CFG_W-1:0] w_cfg_clamp;
    logic [CFG_W-1:0] r_d_eff;
    logic [CFG_W-1:0] r_fill_cnt;
    logic [CFG_W-1:0] w_fill_nxt;
    logic             w_cfg_chg;
    logic             w_accept;
    logic             w_fill_zero;
    logic             w_primed_nxt;
    logic             r_primed;
    logic             r_cfg_err;
    logic             r_vld_p1;
    lnvd_state_t      r_state;
    lnvd_state_t      w_state_nxt;
    lnvd_sel_t        w_sel_p0;
    lnvd_sel_t        r_sel_p1;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] w_rd_addr;
    logic [SUM_W-1:0] w_addr_sum;
    logic [BUS_W-1:0] r_byp_p1;
    logic [BUS_W-1:0] w_ram_q;

    assign w_cfg_clamp = CFG_W'(lnvd_clamp(32'(delay_cfg), 32'(MAX_DEPTH)));
    assign w_cfg_chg   = (w_cfg_clamp != r_d_eff);
    assign w_accept    = in_valid && !rst;
    assign w_fill_zero = (r_state == ST_FILL) && (r_fill_cnt < r_d_eff);

    // wr_ptr - D_eff mod MAX_DEPTH: the biased sum is below 2*MAX_DEPTH, so one fold suffices.
    assign w_addr_sum = SUM_W'(r_wr_ptr) + SUM_W'(MAX_DEPTH) - SUM_W'(r_d_eff);
    assign w_rd_addr  = (w_addr_sum >= SUM_W'(MAX_DEPTH)) ? PTR_W'(w_addr_sum - SUM_W'(MAX_DEPTH))
                                                          : PTR_W'(w_addr_sum);

    always_comb begin
        w_state_nxt  = r_state;
        w_fill_nxt   = r_fill_cnt;
        w_primed_nxt = r_primed;
        if (w_cfg_chg) begin
            w_state_nxt  = ST_FILL;
            w_primed_nxt = 1'b0;
            w_fill_nxt   = w_accept ? CFG_W'(1) : '0;
        end else if (r_state == ST_FILL) begin
            if (r_fill_cnt >= r_d_eff) begin
                w_state_nxt  = ST_RUN;
                w_primed_nxt = 1'b1;
            end else if (w_accept && (r_fill_cnt != MAX_CFG)) begin
                w_fill_nxt = r_fill_cnt + CFG_W'(1);
            end
        end
    end

    always_comb begin
        w_sel_p0 = SEL_RAM;
        if (w_cfg_chg || w_fill_zero) begin
            w_sel_p0 = SEL_ZERO;
        end else if (r_d_eff == '0) begin
            w_sel_p0 = SEL_BYP;
        end
    end

    // p0 -> p1: control state and output select
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_FILL;
            r_fill_cnt <= '0;
            r_wr_ptr   <= '0;
            r_d_eff    <= w_cfg_clamp;
            r_primed   <= 1'b0;
            r_cfg_err  <= 1'b0;
            r_vld_p1   <= 1'b0;
            r_sel_p1   <= SEL_ZERO;
        end else begin
            r_state    <= w_state_nxt;
            r_fill_cnt <= w_fill_nxt;
            r_primed   <= w_primed_nxt;
            r_d_eff    <= w_cfg_clamp;
            r_cfg_err  <= (w_cfg_clamp != delay_cfg);
            r_vld_p1   <= in_valid;
            if (w_accept) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
                r_sel_p1 <= w_sel_p0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_byp_p1 <= data_in;
        end
    end

    lnvd_sdp_ram #(
        .WIDTH(BUS_W),
        .DEPTH(MAX_DEPTH)
    ) u_ram (
        .clk      (clk),
        .i_wr_en  (w_accept),
        .i_wr_addr(r_wr_ptr),
        .i_wr_data(data_in),
        .i_rd_en  (w_accept),
        .i_rd_addr(w_rd_addr),
        .o_rd_data(w_ram_q)
    );

    always_comb begin
        case (r_sel_p1)
            SEL_BYP: data_out = r_byp_p1;
            SEL_RAM: data_out = w_ram_q;
            default: data_out = '0;
        endcase
    end

    assign out_valid = r_vld_p1;
    assign primed    = r_primed;
    assign cfg_err   = r_cfg_err;

endmodule

// File: doc/lnvd_sample_delay_line.md
Name: lnvd_sample_delay_line

Overview:
- Parametrised multi-channel sample delay for the LNVD acquisition path.
- Sits between the ADC capture stage and downstream processing.
- Delays every channel by a run-time programmable number of accepted samples, using a circular buffer.
- Adds valid qualification, a fill/prime state machine, config-change handling and a range-error flag.

Parameters:
DATA_W, 12, bits per channel sample
NUM_CH, 4, number of parallel channels delayed in lockstep
MAX_DEPTH, 64, maximum delay in samples (any integer >= 2, not restricted to a power of two)
PTR_W, $clog2(MAX_DEPTH), buffer address width (derived, not overridden)
CFG_W, $clog2(MAX_DEPTH+1), width of the delay configuration field (derived)

Ports:
clk  in  1  sample-domain clock
rst  in  1  reset; synchronous, active-high
delay_cfg  in  CFG_W  requested delay D in accepted samples
in_valid  in  1  data_in holds a new sample set this cycle
data_in  in  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
out_valid  out  1  data_out holds a delayed sample set
data_out  out  NUM_CH*DATA_W  delayed samples, same packing as data_in
primed  out  1  data_out reflects real history, not fill zeros
cfg_err  out  1  delay_cfg > MAX_DEPTH, so D is being clamped

Behaviour:
- Reset (rst high at a clk edge):
  - out_valid=0, data_out=0, primed=0, cfg_err=0.
  - wr_ptr=0, fill_cnt=0, state=FILL.
  - D_eff is loaded from clamp(delay_cfg).
  - Buffer contents are not cleared.
  - Reset mid-operation discards all history.
- Effective delay:
  - D_eff = min(delay_cfg, MAX_DEPTH).
  - cfg_err is registered and equals (delay_cfg > MAX_DEPTH), one cycle late.
- Acceptance: a sample set is accepted only on a cycle with in_valid=1. Cycles with in_valid=0 do not advance any pointer or counter.
- Latency and output data:
  - out_valid is exactly in_valid delayed one cycle.
  - On that cycle, data_out = sample set accepted D_eff acceptances earlier.
  - D_eff=0: data_out = data_in of the previous cycle (pure register).
  - data_out holds its value while out_valid=0.
- Buffer:
  - MAX_DEPTH entries of NUM_CH*DATA_W bits.
  - Write at wr_ptr on each acceptance; wr_ptr increments and wraps from MAX_DEPTH-1 to 0.
  - Read address = (wr_ptr - D_eff) mod MAX_DEPTH, computed without power-of-two assumptions.
  - D_eff=MAX_DEPTH: read and write address coincide. The read must return the old entry (read-before-write).
- State machine (FILL, RUN):
  - FILL:
    - Each acceptance increments fill_cnt.
    - data_out is forced to 0 while out_valid pulses normally.
    - When the acceptance count reaches D_eff (immediately if D_eff=0), go to RUN and set primed=1.
    - The first RUN output is the first sample accepted after fill start.
  - RUN: outputs are buffer reads; primed stays 1.
- Config change:
  - The block compares clamp(delay_cfg) against D_eff every cycle.
  - On any difference, on the next edge: load the new D_eff, clear fill_cnt, primed=0, state=FILL.
  - wr_ptr is kept; old history is treated as invalid.
  - A change coincident with in_valid: that sample is written and counts as the first fill sample under the new D_eff.
- Simultaneous rst and in_valid: reset wins; the sample is dropped.
- fill_cnt saturates at MAX_DEPTH and never wraps.

Decomposition:
- Shared package lnvd_pkg holds:
  - LNVD_DATA_W=12 and LNVD_NUM_CH=4 defaults
  - state encodings FILL/RUN
  - a clamp helper function for CFG_W values
- One sub-module, lnvd_sdp_ram:
  - simple dual-port RAM (one write port, one synchronous read port)
  - read-before-write on address collision
  - parametrised by width and depth
  - inferable as block RAM

Test Plan:
1. D=3, in_valid every cycle, ramp 1,2,3,... on all channels -> out_valid follows in_valid by 1 cycle; data_out = 0,0,0 then 1,2,3...; primed rises with the output of value 1.
2. D=0 -> data_out equals previous-cycle data_in from the first valid; primed=1 one cycle after reset release.
3. D=MAX_DEPTH=64, 200 samples 0..199 -> output n is n-64 for n>=64, 0 before; covers collision and wrap across 3 laps.
4. D=5, in_valid asserted every 3rd cycle, distinct per-channel values (ch k = 100k+n) -> delay is counted in accepted samples; data_out holds between pulses; channels are not swapped.
5. In RUN at D=4, change to D=2 coincident with in_valid -> primed drops next cycle; 2 zero outputs follow, then correct 2-sample delay; wr_ptr continuity is preserved.
6. delay_cfg=100 (above MAX_DEPTH) -> cfg_err=1 one cycle later and behaviour matches D=64. Then assert rst mid-stream -> all outputs 0, primed=0, and fill restarts from zero.
